column_scheduler: RTL and testbench
===================================

Name: column_scheduler

Overview:
- Sequencing controller in front of one column reducer: operator ×/+ with 32-bit operands and a 64-bit result.
- Accepts a valid/ready stream of column beats from the worksheet parser: one operator beat, then number beats.
- Drives the reducer's num_valid/num_in/op_valid/op_in/done pulses and waits for its result.
- Accumulates the grand total over a sheet and reports it once, plus column count and error flags.

Parameters:
- NUM_W, 32, operand width (matches reducer num_in)
- RES_W, 64, reducer result width
- TOT_W, 64, grand-total accumulator width
- CNT_W, 16, column counter width
- TIMEOUT, 256, max cycles in WAIT for red_result_valid before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 resets on the clock edge)
- in_valid  in  1  upstream beat valid
- in_ready  out  1  scheduler can accept a beat
- in_is_op  in  1  beat is an operator beat (1) or number beat (0)
- in_op  in  1  operator on op beat: 1=multiply, 0=add
- in_data  in  NUM_W  operand on number beat
- in_last  in  1  last beat of column (number beat, or op beat of an empty column)
- in_sheet_end  in  1  with in_last: this column ends the sheet
- red_num_valid  out  1  one-cycle operand strobe to reducer
- red_num_in  out  NUM_W  operand to reducer
- red_op_valid  out  1  one-cycle operator strobe
- red_op_in  out  1  operator to reducer
- red_done  out  1  one-cycle end-of-column strobe
- red_result_valid  in  1  reducer result strobe
- red_result  in  RES_W  reducer column result
- total  out  TOT_W  last reported sheet total (held)
- total_valid  out  1  one-cycle strobe, total updated
- col_count  out  CNT_W  columns completed in current sheet
- busy  out  1  state != IDLE
- err_proto  out  1  sticky: protocol violation seen
- err_timeout  out  1  sticky: reducer timeout
- ovf  out  1  sticky: accumulator carry-out

Behaviour:
- Reset (rst=0 at edge): state=IDLE. All red_* strobes, total_valid and sticky flags are 0. total=0, accumulator=0, col_count=0, timeout counter=0. Reset mid-column abandons the column; the reducer is not notified.
- in_ready=1 in IDLE and NUMS; 0 in DONE and WAIT. Beat accepted when in_valid&in_ready.
- Strobes are registered: an accepted beat at edge t gives its red_* strobe high for exactly cycle t+1. red_num_in/red_op_in hold their last value otherwise.
- IDLE, op beat accepted: red_op_valid=1, red_op_in=in_op.
  - If in_last=0: go to NUMS.
  - If in_last=1 (empty column): no reducer activity; contributes 0 and col_count+1. If in_sheet_end also set, total_valid as below. Stay in IDLE.
- IDLE, number beat: err_proto=1, beat dropped, stay IDLE.
- NUMS, number beat: red_num_valid=1, red_num_in=in_data. If in_last, latch in_sheet_end and go to DONE.
- NUMS, op beat: err_proto=1, beat dropped, stay NUMS.
- DONE: red_done=1 for one cycle, then go to WAIT with the timeout counter cleared.
- WAIT, red_result_valid=1:
  - acc_next = acc + zero-extended red_result, mod 2^TOT_W; carry-out sets ovf.
  - col_count+1; go to IDLE.
  - If sheet_end is latched: total=acc_next, total_valid=1 on the next cycle, acc=0, col_count=0. This takes priority over the increment.
  - Otherwise acc=acc_next.
- WAIT, no result for TIMEOUT cycles: err_timeout=1, column discarded (acc unchanged), go to IDLE. A sheet_end column that times out still reports total=acc and clears.
- red_result_valid outside WAIT is ignored.
- Sticky flags clear only on reset.

Test Plan:
- Sheet of 4 columns: (op=1; 123, 45, 6), (op=0; 328, 64, 98), (op=1; 51, 387, 215), (op=0; 64, 23, 314 with in_sheet_end), using a reducer model with 3-cycle result latency.
  - Required: reducer results 33210, 490, 4243455, 401.
  - total=4277556 with a single total_valid pulse; col_count returns to 0; no flags set.
- Single-column timing, op=1 then 7 (in_last, in_sheet_end), accepted at edges t0 and t0+1.
  - red_op_valid at t0+1, red_num_valid at t0+2, red_done at t0+3, in_ready=0 from t0+3.
  - Result 7 → total=7, total_valid one cycle after red_result_valid.
- Empty column (op beat with in_last=1, in_sheet_end=1) after a column giving 10: total=10, no red_num_valid/red_done for the empty column.
- Protocol errors: number beat in IDLE, op beat in NUMS → err_proto=1, beats dropped. A following valid column (op=0; 2, 3, sheet end) gives total=5.
- Reducer never responds → err_timeout=1 after 256 WAIT cycles, returns to IDLE, in_ready=1. Next column (op=0; 4, sheet end) gives total=4.
- Overflow: two columns with results 2^64−1 and 2, sheet end → total=1, ovf=1. Then assert rst=0 mid-NUMS: all outputs return to reset values.

Source files
------------

// File: rtl/column_scheduler.sv
// Sequences one column reducer from a valid/ready beat stream (op beat, then numbers)
// and accumulates a per-sheet grand total with column count and sticky error flags.
module column_scheduler #(
  parameter int NUM_W   = 32,
  parameter int RES_W   = 64,
  parameter int TOT_W   = 64,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_op,
  input  logic             in_op,
  input  logic [NUM_W-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sheet_end,
  output logic             red_num_valid,
  output logic [NUM_W-1:0] red_num_in,
  output logic             red_op_valid,
  output logic             red_op_in,
  output logic             red_done,
  input  logic             red_result_valid,
  input  logic [RES_W-1:0] red_result,
  output logic [TOT_W-1:0] total,
  output logic             total_valid,
  output logic [CNT_W-1:0] col_count,
  output logic             busy,
  output logic             err_proto,
  output logic             err_timeout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Upstream handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_NUMS, S_DONE, S_WAIT} state_t;
  localparam int TO_W = $clog2(TIMEOUT + 1);

  state_t state_q, state_d;
  logic             num_valid_q, num_valid_d, op_valid_q, op_valid_d, done_q, done_d;
  logic [NUM_W-1:0] num_in_q, num_in_d;
  logic             op_in_q, op_in_d;
  logic [TOT_W-1:0] acc_q, acc_d, total_q, total_d;
  logic             total_valid_q, total_valid_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             sheet_end_q, sheet_end_d;
  logic             err_proto_q, err_proto_d, err_timeout_q, err_timeout_d, ovf_q, ovf_d;
  logic             accept, timeout_hit;
  logic [TOT_W:0]   sum_w;

  assign in_ready    = (state_q == S_IDLE) || (state_q == S_NUMS);
  assign accept      = in_valid && in_ready;
  assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign sum_w       = {1'b0, acc_q} + (TOT_W + 1)'(red_result);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && in_is_op && !in_last) state_d = S_NUMS;
      S_NUMS: if (accept && !in_is_op && in_last) state_d = S_DONE;
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (red_result_valid || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    num_valid_d   = 1'b0;
    op_valid_d    = 1'b0;
    done_d        = 1'b0;
    total_valid_d = 1'b0;
    num_in_d      = num_in_q;
    op_in_d       = op_in_q;
    acc_d         = acc_q;
    total_d       = total_q;
    col_d         = col_q;
    to_cnt_d      = to_cnt_q;
    sheet_end_d   = sheet_end_q;
    err_proto_d   = err_proto_q;
    err_timeout_d = err_timeout_q;
    ovf_d         = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (accept && in_is_op && !in_last) begin
          op_valid_d = 1'b1;
          op_in_d    = in_op;
        end else if (accept && in_is_op) begin
          // Empty column adds nothing; it never reaches the reducer.
          if (in_sheet_end) begin
            total_d       = acc_q;
            total_valid_d = 1'b1;
            acc_d         = '0;
            col_d         = '0;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end else if (accept) begin
          err_proto_d = 1'b1;
        end
      end
      S_NUMS: begin
        if (accept && !in_is_op) begin
          num_valid_d = 1'b1;
          num_in_d    = in_data;
          if (in_last) sheet_end_d = in_sheet_end;
        end else if (accept) begin
          err_proto_d = 1'b1;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        to_cnt_d = '0;
      end
      S_WAIT: begin
        if (red_result_valid) begin
          ovf_d = ovf_q | sum_w[TOT_W];
          if (sheet_end_q) begin
            total_d       = sum_w[TOT_W-1:0];
            total_valid_d = 1'b1;
            acc_d         = '0;
            col_d         = '0;
          end else begin
            acc_d = sum_w[TOT_W-1:0];
            col_d = col_q + CNT_W'(1);
          end
        end else if (timeout_hit) begin
          // Timed-out column is discarded, but a sheet end still reports.
          err_timeout_d = 1'b1;
          if (sheet_end_q) begin
            total_d       = acc_q;
            total_valid_d = 1'b1;
            acc_d         = '0;
            col_d         = '0;
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      num_valid_q   <= 1'b0;
      op_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      total_valid_q <= 1'b0;
      num_in_q      <= '0;
      op_in_q       <= 1'b0;
      acc_q         <= '0;
      total_q       <= '0;
      col_q         <= '0;
      to_cnt_q      <= '0;
      sheet_end_q   <= 1'b0;
      err_proto_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      num_valid_q   <= num_valid_d;
      op_valid_q    <= op_valid_d;
      done_q        <= done_d;
      total_valid_q <= total_valid_d;
      num_in_q      <= num_in_d;
      op_in_q       <= op_in_d;
      acc_q         <= acc_d;
      total_q       <= total_d;
      col_q         <= col_d;
      to_cnt_q      <= to_cnt_d;
      sheet_end_q   <= sheet_end_d;
      err_proto_q   <= err_proto_d;
      err_timeout_q <= err_timeout_d;
      ovf_q         <= ovf_d;
    end
  end

  assign red_num_valid = num_valid_q;
  assign red_num_in    = num_in_q;
  assign red_op_valid  = op_valid_q;
  assign red_op_in     = op_in_q;
  assign red_done      = done_q;
  assign total         = total_q;
  assign total_valid   = total_valid_q;
  assign col_count     = col_q;
  assign busy          = (state_q != S_IDLE);
  assign err_proto     = err_proto_q;
  assign err_timeout   = err_timeout_q;
  assign ovf           = ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler with a small behavioural reducer (3-cycle latency).
module tb_column_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_is_op = 1'b0, in_op = 1'b0, in_last = 1'b0, in_sheet_end = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        red_num_valid, red_op_valid, red_op_in, red_done;
  logic [31:0] red_num_in;
  logic        red_result_valid = 1'b0;
  logic [63:0] red_result = '0;
  logic [63:0] total;
  logic        total_valid, busy, err_proto, err_timeout, ovf;
  logic [15:0] col_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  column_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_op(in_is_op), .in_op(in_op),
    .in_data(in_data), .in_last(in_last), .in_sheet_end(in_sheet_end),
    .red_num_valid(red_num_valid), .red_num_in(red_num_in),
    .red_op_valid(red_op_valid), .red_op_in(red_op_in), .red_done(red_done),
    .red_result_valid(red_result_valid), .red_result(red_result),
    .total(total), .total_valid(total_valid), .col_count(col_count), .busy(busy),
    .err_proto(err_proto), .err_timeout(err_timeout), .ovf(ovf), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural reducer, updated on the falling edge so its outputs are stable at rising edges
  logic        model_en = 1'b1;
  logic        override_en = 1'b0;
  logic [63:0] override_val = '0;
  logic        m_op = 1'b0;
  logic [63:0] m_acc = '0;
  int          m_lat = 0;
  logic [63:0] got_res[$];
  int          tv_cnt = 0, nv_cnt = 0, dn_cnt = 0;

  always @(negedge clk) begin
    red_result_valid = 1'b0;
    if (red_op_valid) begin
      m_op  = red_op_in;
      m_acc = red_op_in ? 64'd1 : 64'd0;
    end
    if (red_num_valid) m_acc = m_op ? m_acc * 64'(red_num_in) : m_acc + 64'(red_num_in);
    if (red_done && model_en) begin
      m_lat = 3;
    end else if (m_lat > 0) begin
      m_lat = m_lat - 1;
      if (m_lat == 0) begin
        red_result_valid = 1'b1;
        red_result = override_en ? override_val : m_acc;
        got_res.push_back(red_result);
      end
    end
    if (total_valid)   tv_cnt++;
    if (red_num_valid) nv_cnt++;
    if (red_done)      dn_cnt++;
  end

  // driver tasks
  task automatic send_beat(input logic is_op, input logic op, input logic [31:0] data,
                           input logic last, input logic se);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_is_op = is_op; in_op = op; in_data = data;
    in_last = last; in_sheet_end = se;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++; failures++;
      $display("FAIL send_beat_ready got=0 exp=1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_sheet_end = 1'b0;
  endtask

  task automatic wait_tv();
    int n = 0;
    @(negedge clk);
    while (!total_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; failures++;
      $display("FAIL wait_total_valid got=0 exp=1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL reset_ready_busy got=%b%b exp=10", in_ready, busy); end
    checks++; if (total !== 64'd0 || total_valid !== 1'b0 || col_count !== 16'd0) begin failures++;
      $display("FAIL reset_total got=%0d/%b/%0d exp=0/0/0", total, total_valid, col_count); end
    checks++; if ({err_proto, err_timeout, ovf} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {err_proto, err_timeout, ovf}); end
    checks++; if ({red_num_valid, red_op_valid, red_done} !== 3'b000) begin failures++;
      $display("FAIL reset_strobes got=%b exp=000", {red_num_valid, red_op_valid, red_done}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sheet();
    logic [63:0] exp_res[4] = '{64'd33210, 64'd490, 64'd4243455, 64'd401};
    int base = got_res.size();
    int tv0 = tv_cnt;
    send_beat(1, 1, 0, 0, 0); send_beat(0, 0, 123, 0, 0); send_beat(0, 0, 45, 0, 0); send_beat(0, 0, 6, 1, 0);
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 328, 0, 0); send_beat(0, 0, 64, 0, 0); send_beat(0, 0, 98, 1, 0);
    send_beat(1, 1, 0, 0, 0); send_beat(0, 0, 51, 0, 0); send_beat(0, 0, 387, 0, 0); send_beat(0, 0, 215, 1, 0);
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 64, 0, 0); send_beat(0, 0, 23, 0, 0); send_beat(0, 0, 314, 1, 1);
    wait_tv();
    checks++; if (total !== 64'd4277556) begin failures++;
      $display("FAIL sheet_total got=%0d exp=4277556", total); end
    repeat (5) @(negedge clk);
    checks++; if (got_res.size() - base !== 4) begin failures++;
      $display("FAIL sheet_result_count got=%0d exp=4", got_res.size() - base); end
    for (int i = 0; i < 4 && base + i < got_res.size(); i++) begin
      checks++; if (got_res[base + i] !== exp_res[i]) begin failures++;
        $display("FAIL sheet_result%0d got=%0d exp=%0d", i, got_res[base + i], exp_res[i]); end
    end
    checks++; if (tv_cnt - tv0 !== 1) begin failures++;
      $display("FAIL sheet_tv_pulses got=%0d exp=1", tv_cnt - tv0); end
    checks++; if (col_count !== 16'd0 || {err_proto, err_timeout, ovf} !== 3'b000) begin failures++;
      $display("FAIL sheet_cnt_flags got=%0d/%b exp=0/000", col_count, {err_proto, err_timeout, ovf}); end
  endtask

  task automatic test_timing();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_is_op = 1'b1; in_op = 1'b1; in_last = 1'b0; in_sheet_end = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (red_op_valid !== 1'b1 || red_op_in !== 1'b1) begin failures++;
      $display("FAIL timing_op got=%b%b exp=11", red_op_valid, red_op_in); end
    in_is_op = 1'b0; in_data = 32'd7; in_last = 1'b1; in_sheet_end = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (red_num_valid !== 1'b1 || red_num_in !== 32'd7 || red_op_valid !== 1'b0 || red_done !== 1'b0) begin
      failures++; $display("FAIL timing_num got=%b/%0d/%b/%b exp=1/7/0/0",
                           red_num_valid, red_num_in, red_op_valid, red_done); end
    in_valid = 1'b0; in_last = 1'b0; in_sheet_end = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (red_done !== 1'b1 || in_ready !== 1'b0 || red_num_valid !== 1'b0) begin failures++;
      $display("FAIL timing_done got=%b/%b/%b exp=1/0/0", red_done, in_ready, red_num_valid); end
    @(negedge clk); #1;
    while (!red_result_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checks++; if (n >= 100) begin failures++;
      $display("FAIL timing_result_wait got=0 exp=1"); end
    checks++; if (total_valid !== 1'b0) begin failures++;
      $display("FAIL timing_tv_early got=%b exp=0", total_valid); end
    @(negedge clk);
    checks++; if (total_valid !== 1'b1 || total !== 64'd7) begin failures++;
      $display("FAIL timing_total got=%b/%0d exp=1/7", total_valid, total); end
  endtask

  task automatic test_empty();
    int nv0, dn0, n = 0;
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 10, 1, 0);
    while (col_count !== 16'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (col_count !== 16'd1) begin failures++;
      $display("FAIL empty_first_col got=%0d exp=1", col_count); end
    nv0 = nv_cnt; dn0 = dn_cnt;
    send_beat(1, 1, 0, 1, 1);
    wait_tv();
    checks++; if (total !== 64'd10) begin failures++;
      $display("FAIL empty_total got=%0d exp=10", total); end
    repeat (4) @(negedge clk);
    checks++; if (nv_cnt - nv0 !== 0 || dn_cnt - dn0 !== 0) begin failures++;
      $display("FAIL empty_reducer_idle got=%0d/%0d exp=0/0", nv_cnt - nv0, dn_cnt - dn0); end
    checks++; if (col_count !== 16'd0 || busy !== 1'b0) begin failures++;
      $display("FAIL empty_state got=%0d/%b exp=0/0", col_count, busy); end
  endtask

  task automatic test_proto();
    int nv0 = nv_cnt;
    send_beat(0, 0, 99, 0, 0);
    @(negedge clk);
    checks++; if (err_proto !== 1'b1 || busy !== 1'b0 || nv_cnt !== nv0) begin failures++;
      $display("FAIL proto_idle got=%b/%b/%0d exp=1/0/0", err_proto, busy, nv_cnt - nv0); end
    send_beat(1, 0, 0, 0, 0);
    send_beat(1, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1 || dbg_state !== 2'd1) begin failures++;
      $display("FAIL proto_nums got=%b/%b/%0d exp=1/1/1", busy, in_ready, dbg_state); end
    send_beat(0, 0, 2, 0, 0); send_beat(0, 0, 3, 1, 1);
    wait_tv();
    checks++; if (total !== 64'd5) begin failures++;
      $display("FAIL proto_total got=%0d exp=5", total); end
  endtask

  task automatic test_timeout();
    int n = 0;
    model_en = 1'b0;
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 9, 1, 0);
    while (!red_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!err_timeout && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 256) begin failures++;
      $display("FAIL timeout_cycles got=%0d exp=256", n); end
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || col_count !== 16'd0) begin failures++;
      $display("FAIL timeout_state got=%b/%b/%0d exp=1/0/0", in_ready, busy, col_count); end
    model_en = 1'b1;
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 4, 1, 1);
    wait_tv();
    checks++; if (total !== 64'd4) begin failures++;
      $display("FAIL timeout_next_total got=%0d exp=4", total); end
  endtask

  task automatic test_overflow_reset();
    override_en = 1'b1; override_val = 64'hFFFF_FFFF_FFFF_FFFF;
    send_beat(1, 0, 0, 0, 0); send_beat(0, 0, 5, 1, 0);
    send_beat(1, 0, 0, 0, 0);
    override_val = 64'd2;
    send_beat(0, 0, 5, 1, 1);
    wait_tv();
    checks++; if (total !== 64'd1 || ovf !== 1'b1) begin failures++;
      $display("FAIL ovf_total got=%0d/%b exp=1/1", total, ovf); end
    override_en = 1'b0;
    send_beat(1, 1, 0, 0, 0); send_beat(0, 0, 77, 0, 0);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++;
      $display("FAIL midcol_busy got=%b exp=1", busy); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (total !== 64'd0 || col_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b1) begin failures++;
      $display("FAIL midcol_reset got=%0d/%0d/%b/%b exp=0/0/0/1", total, col_count, busy, in_ready); end
    checks++; if ({err_proto, err_timeout, ovf, total_valid} !== 4'b0000) begin failures++;
      $display("FAIL midcol_flags got=%b exp=0000", {err_proto, err_timeout, ovf, total_valid}); end
    checks++; if (red_num_in !== 32'd0 || red_op_in !== 1'b0 || {red_num_valid, red_op_valid, red_done} !== 3'b000) begin
      failures++; $display("FAIL midcol_red got=%0d/%b/%b exp=0/0/000",
                           red_num_in, red_op_in, {red_num_valid, red_op_valid, red_done}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sheet();
    test_timing();
    test_empty();
    test_proto();
    test_timeout();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
